// File: rtl/enemy_row_formation.sv
// ============================================================================
// Module   : enemy_row_formation
// Purpose  : Row-level mover for one horizontal row of enemies. It sweeps, drops,
//            tracks kills and flags a cleared or landed row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_row_formation #(
    parameter int                 ENEMY_COUNT = 4,
    parameter int                 X_WIDTH     = 10,
    parameter int                 Y_WIDTH     = 9,
    parameter logic [X_WIDTH-1:0] START_X     = 10'd100,
    parameter logic [Y_WIDTH-1:0] START_Y     = 9'd108,
    parameter logic [X_WIDTH-1:0] SPACING     = 10'd48,
    parameter logic [X_WIDTH-1:0] ENEMY_WIDTH = 10'd32,
    parameter logic [X_WIDTH-1:0] STEP        = 10'd1,
    parameter logic [Y_WIDTH-1:0] DROP        = 9'd16,
    parameter logic [X_WIDTH-1:0] X_MIN       = 10'd8,
    parameter logic [X_WIDTH-1:0] X_MAX       = 10'd639,
    parameter logic [Y_WIDTH-1:0] Y_LIMIT     = 9'd400
) (
    input  logic                                       i_Clk,
    input  logic                                       i_Rst,
    input  logic                                       i_Tick,
    input  logic [ENEMY_COUNT-1:0]                     i_Kill,
    input  logic                                       i_Restart,
    output logic [ENEMY_COUNT*(X_WIDTH+Y_WIDTH)-1:0]   o_EnemyPosition,
    output logic [ENEMY_COUNT-1:0]                     o_AliveMask,
    output logic                                       o_Direction,
    output logic                                       o_AllDead,
    output logic                                       o_Landed
);

    localparam int c_W  = X_WIDTH + Y_WIDTH;
    localparam int c_EW = X_WIDTH + 2;
    localparam int c_YW = Y_WIDTH + 1;
    localparam int c_IW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;

    localparam logic [2:0] c_MOVE_R    = 3'd0;
    localparam logic [2:0] c_MOVE_L    = 3'd1;
    localparam logic [2:0] c_DROP_TO_L = 3'd2;
    localparam logic [2:0] c_DROP_TO_R = 3'd3;
    localparam logic [2:0] c_CLEARED   = 3'd4;
    localparam logic [2:0] c_LANDED    = 3'd5;

    logic [2:0]               r_State;
    logic [X_WIDTH-1:0]       r_RowX;
    logic [Y_WIDTH-1:0]       r_RowY;
    logic [ENEMY_COUNT-1:0]   r_Alive;
    logic                     r_Direction;
    logic                     r_AllDead;
    logic                     r_Landed;
    logic [ENEMY_COUNT*c_W-1:0] r_EnemyPosition;

    logic [2:0]               w_nextState;
    logic [X_WIDTH-1:0]       w_nextX;
    logic [Y_WIDTH-1:0]       w_nextY;
    logic [ENEMY_COUNT-1:0]   w_nextAlive;
    logic                     w_nextDir;
    logic                     w_nextAllDead;
    logic                     w_nextLanded;
    logic [ENEMY_COUNT-1:0]   w_killedMask;
    logic [c_IW-1:0]          w_lowIdx;
    logic [c_IW-1:0]          w_highIdx;
    logic [c_EW-1:0]          w_rightEdge;
    logic [c_EW-1:0]          w_leftEdge;
    logic [c_YW-1:0]          w_dropY;
    logic                     w_hitRight;
    logic                     w_hitLeft;
    logic                     w_hitFloor;
    logic [ENEMY_COUNT*c_W-1:0] w_nextPos;
    logic [ENEMY_COUNT*c_W-1:0] w_startPos;

    // Edge enemies come from the registered mask, so same-cycle kills never move the edge test.
    always_comb begin
        w_lowIdx  = '0;
        w_highIdx = '0;
        for (int k = ENEMY_COUNT - 1; k >= 0; k--) begin
            if (r_Alive[k]) w_lowIdx = c_IW'(k);
        end
        for (int k = 0; k < ENEMY_COUNT; k++) begin
            if (r_Alive[k]) w_highIdx = c_IW'(k);
        end
    end

    assign w_killedMask = r_Alive & ~i_Kill;
    assign w_rightEdge  = c_EW'(r_RowX) + c_EW'(w_highIdx) * c_EW'(SPACING)
                        + c_EW'(ENEMY_WIDTH) - c_EW'(1) + c_EW'(STEP);
    assign w_leftEdge   = c_EW'(r_RowX) + c_EW'(w_lowIdx) * c_EW'(SPACING);
    assign w_hitRight   = w_rightEdge > c_EW'(X_MAX);
    assign w_hitLeft    = w_leftEdge < (c_EW'(X_MIN) + c_EW'(STEP));
    assign w_dropY      = c_YW'(r_RowY) + c_YW'(DROP);
    assign w_hitFloor   = w_dropY > c_YW'(Y_LIMIT);

    always_comb begin
        w_nextState   = r_State;
        w_nextX       = r_RowX;
        w_nextY       = r_RowY;
        w_nextAlive   = r_Alive;
        w_nextDir     = r_Direction;
        w_nextAllDead = r_AllDead;
        w_nextLanded  = r_Landed;
        case (r_State)
            c_CLEARED: ;
            c_LANDED: begin
                w_nextAlive = w_killedMask;
                if (w_killedMask == '0) w_nextAllDead = 1'b1;
            end
            c_MOVE_R, c_MOVE_L, c_DROP_TO_L, c_DROP_TO_R: begin
                w_nextAlive = w_killedMask;
                if (w_killedMask == '0) begin
                    w_nextState   = c_CLEARED;
                    w_nextAllDead = 1'b1;
                end else if (i_Tick) begin
                    case (r_State)
                        c_MOVE_R: begin
                            if (w_hitRight) w_nextState = c_DROP_TO_L;
                            else            w_nextX     = r_RowX + STEP;
                        end
                        c_MOVE_L: begin
                            if (w_hitLeft) w_nextState = c_DROP_TO_R;
                            else           w_nextX     = r_RowX - STEP;
                        end
                        default: begin
                            if (w_hitFloor) begin
                                w_nextState  = c_LANDED;
                                w_nextLanded = 1'b1;
                            end else begin
                                w_nextY     = r_RowY + DROP;
                                w_nextDir   = ~r_Direction;
                                w_nextState = (r_State == c_DROP_TO_L) ? c_MOVE_L : c_MOVE_R;
                            end
                        end
                    endcase
                end
            end
            default: w_nextState = c_MOVE_R;
        endcase
    end

    for (genvar k = 0; k < ENEMY_COUNT; k++) begin : g_pos
        localparam logic [X_WIDTH-1:0] c_OFFSET = X_WIDTH'(k * SPACING);
        assign w_nextPos[k*c_W +: c_W]  = w_nextAlive[k] ? {w_nextX + c_OFFSET, w_nextY}
                                                         : {c_W{1'b1}};
        assign w_startPos[k*c_W +: c_W] = {START_X + c_OFFSET, START_Y};
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst || i_Restart) begin
            r_State         <= c_MOVE_R;
            r_RowX          <= START_X;
            r_RowY          <= START_Y;
            r_Alive         <= '1;
            r_Direction     <= 1'b0;
            r_AllDead       <= 1'b0;
            r_Landed        <= 1'b0;
            r_EnemyPosition <= w_startPos;
        end else begin
            r_State         <= w_nextState;
            r_RowX          <= w_nextX;
            r_RowY          <= w_nextY;
            r_Alive         <= w_nextAlive;
            r_Direction     <= w_nextDir;
            r_AllDead       <= w_nextAllDead;
            r_Landed        <= w_nextLanded;
            r_EnemyPosition <= w_nextPos;
        end
    end

    assign o_EnemyPosition = r_EnemyPosition;
    assign o_AliveMask     = r_Alive;
    assign o_Direction     = r_Direction;
    assign o_AllDead       = r_AllDead;
    assign o_Landed        = r_Landed;

endmodule

`default_nettype wire

// File: doc/enemy_row_formation.md
Name: enemy_row_formation

Overview:
- Registered, parametrised mover for one horizontal row of ENEMY_COUNT enemies in the shooter game. It replaces per-enemy combinational phase stepping with a row-level state machine.
- It sweeps the row right and left on a movement tick, drops the row and reverses direction at screen edges, and tracks which enemies are alive.
- It detects row-cleared and row-landed conditions. Outputs feed the renderer and the collision block.

Parameters:
- ENEMY_COUNT, 4: enemies in the row (1..16).
- X_WIDTH, 10: horizontal coordinate width.
- Y_WIDTH, 9: vertical coordinate width.
- START_X, 10'd100: x of enemy 0 after reset or restart.
- START_Y, 9'd108: row y after reset or restart.
- SPACING, 10'd48: x pitch between adjacent enemies.
- ENEMY_WIDTH, 10'd32: sprite width, used for right-edge test.
- STEP, 10'd1: x pixels moved per tick.
- DROP, 9'd16: y pixels descended per drop.
- X_MIN, 10'd8: leftmost legal x of any alive enemy.
- X_MAX, 10'd639: rightmost legal pixel of any alive enemy.
- Y_LIMIT, 9'd400: row y beyond which the row has landed.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst, input, 1: synchronous, active-low reset.
- i_Tick, input, 1: one-cycle movement strobe.
- i_Kill, input, ENEMY_COUNT: per-enemy hit pulses from collision; any number of bits may be set.
- i_Restart, input, 1: reload formation; same effect as reset.
- o_EnemyPosition, output, ENEMY_COUNT*(X_WIDTH+Y_WIDTH): packed positions. Enemy k occupies bits [(k+1)*W-1 : k*W], W = X_WIDTH+Y_WIDTH, formatted {x, y}.
- o_AliveMask, output, ENEMY_COUNT: registered alive bits.
- o_Direction, output, 1: 0 = moving right, 1 = moving left.
- o_AllDead, output, 1: row cleared.
- o_Landed, output, 1: row reached Y_LIMIT.

Behaviour:
- Reset and restart (reset has priority):
  - RowX=START_X, RowY=START_Y, alive mask all ones, state MOVE_R.
  - o_Direction=0, o_AllDead=0, o_Landed=0.
  - o_EnemyPosition loads reset values on the same edge.
- Enemy position:
  - Enemy k x = RowX + k*SPACING, truncated to X_WIDTH; y = RowY.
  - A dead enemy outputs NONE = all ones (W bits).
  - All outputs are registered and reflect state one cycle after the causing event.
- Edge indices: L = lowest alive index, R = highest alive index, computed from the registered mask. Kills in the current cycle do not affect this cycle's edge test.
- States: MOVE_R, MOVE_L, DROP_TO_L, DROP_TO_R, CLEARED, LANDED. Transitions happen only when i_Tick=1, except entry to CLEARED.
- MOVE_R: if RowX + R*SPACING + ENEMY_WIDTH - 1 + STEP > X_MAX, go to DROP_TO_L with RowX unchanged. Else RowX += STEP.
- MOVE_L: if RowX + L*SPACING < X_MIN + STEP, go to DROP_TO_R with RowX unchanged. Else RowX -= STEP.
- DROP_TO_L / DROP_TO_R:
  - If RowY + DROP > Y_LIMIT, go to LANDED with RowY unchanged.
  - Else RowY += DROP and go to MOVE_L / MOVE_R respectively.
  - o_Direction toggles on the drop tick.
- Arithmetic: edge comparisons use X_WIDTH+2 bits unsigned so no wrap occurs.
- Kills: alive bit k clears on the edge where i_Kill[k]=1. Killing an already dead enemy has no effect. A kill and a tick in the same cycle both take effect.
- CLEARED: entered on the edge where the next alive mask becomes zero, from any moving or drop state. Kill has priority over a simultaneous tick. o_AllDead=1, positions all NONE, frozen until reset or restart.
- LANDED: o_Landed=1, positions frozen, kills still honoured. If the mask empties in LANDED, o_AllDead=1 but the state stays LANDED.
- i_Tick while frozen: ignored.
- Reset mid-drop or mid-move: immediate full reload, no partial update.

Test Plan:
- Reset: hold i_Rst=0 for 2 cycles, release -> enemy 0={100,108}, enemy 3={244,108}, mask=4'b1111, direction=0, flags 0.
- Right sweep: 364 ticks -> RowX=464. Tick 365 -> state DROP_TO_L, RowX=464. Tick 366 -> RowY=124, direction=1, enemy 0={464,124}.
- Left sweep: continue 456 ticks -> RowX=8. Next tick -> drop, RowY=140, direction=0.
- Kill rightmost: after reset pulse i_Kill=4'b1000 -> enemy 3 = all ones next cycle. Right travel now drops after RowX=512 instead of 464.
- Kill and tick same cycle: at RowX=200 pulse i_Kill=4'b0001 with i_Tick -> RowX=201, enemy 0 NONE. Then kill 4'b1110 -> o_AllDead=1, all NONE, further ticks ignored.
- Landing and reset: drive drops until RowY=396. Next drop tick -> o_Landed=1, RowY=396. Assert i_Rst=0 mid-DROP on a second run -> full reload to reset values.
